// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one operand bit per clock, MSB first).
// Optional overflow flag output enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int BW   = 4 * DIGITS;
  localparam int SW   = BW + WIDTH;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   shift_reg;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;

  // Binary field passes through; each BCD nibble >= 5 gets +3 with no carry into its neighbour.
  assign adj[WIDTH-1:0] = shift_reg[WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      logic [3:0] nib;
      assign nib = shift_reg[WIDTH + 4*gi +: 4];
      assign adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign shifted = adj << 1;

`ifdef BIN2BCD_OVF_EN
  logic ovf_sticky;
  logic carry;
  // Bit leaving the top nibble means the value needs more than DIGITS digits.
  assign carry = adj[SW-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
`ifdef BIN2BCD_OVF_EN
      ovf_sticky <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shift_reg <= {{BW{1'b0}}, bin_in};
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
`ifdef BIN2BCD_OVF_EN
            ovf_sticky <= 1'b0;
            ovf        <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shift_reg <= shifted;
          cnt       <= cnt + CW'(1);
`ifdef BIN2BCD_OVF_EN
          ovf_sticky <= ovf_sticky | carry;
`endif
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= shifted[SW-1 -: BW];
`ifdef BIN2BCD_OVF_EN
            ovf     <= ovf_sticky | carry;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an 8-bit/3-digit and a 10-bit/3-digit instance.
// Stimulus pushes expected results; per-DUT monitors pop and compare on every done pulse.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  bin_a;
  logic [9:0]  bin_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [11:0] bcd_a, bcd_b;
`ifdef BIN2BCD_OVF_EN
  logic        ovf_a, ovf_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_a[$];
  logic [12:0] exp_b[$];   // {ovf, bcd}

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a)
`ifdef BIN2BCD_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b)
`ifdef BIN2BCD_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_nibbles(input string name, input logic [11:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  // Monitors: compare on every done pulse, and police busy/done exclusivity.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (exp_a.size() == 0) chk("unexpected_done_a", 32'd1, 32'd0);
      else chk("bcd_a", {20'd0, bcd_a}, {20'd0, exp_a.pop_front()});
      chk_nibbles("nibbles_a", bcd_a);
    end
    if (busy_a && done_a) chk("busy_done_excl_a", 32'd1, 32'd0);
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n && done_b) begin
      if (exp_b.size() == 0) chk("unexpected_done_b", 32'd1, 32'd0);
      else begin
        e = exp_b.pop_front();
        chk("bcd_b", {20'd0, bcd_b}, {20'd0, e[11:0]});
`ifdef BIN2BCD_OVF_EN
        chk("ovf_b", {31'd0, ovf_b}, {31'd0, e[12]});
`endif
      end
      chk_nibbles("nibbles_b", bcd_b);
    end
    if (busy_b && done_b) chk("busy_done_excl_b", 32'd1, 32'd0);
  end

  // One conversion: checks latency, busy length, bcd_out stability during SHIFT and done pulse width.
  task automatic run_conv(input bit b, input logic [15:0] v, input logic [12:0] e);
    int n, nb, w;
    bit stable;
    logic [11:0] hold;
    w = b ? 10 : 8;
    @(negedge clk);
    if (b) begin start_b = 1'b1; bin_b = v[9:0]; exp_b.push_back(e); end
    else begin start_a = 1'b1; bin_a = v[7:0]; exp_a.push_back(e[11:0]); end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    bin_a = ~bin_a; bin_b = ~bin_b;
    hold = b ? bcd_b : bcd_a;
    n = 0; nb = 0; stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (b ? done_b : done_a) break;
      if (b ? busy_b : busy_a) begin
        nb++;
        if ((b ? bcd_b : bcd_a) !== hold) stable = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, w);
    chk("busy_cycles", nb, w);
    chk("bcd_stable_in_shift", {31'd0, stable}, 32'd1);
    $display("conv dut=%s bin=%0d expected=%03h latency=%0d", b ? "b" : "a", v, e[11:0], n);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, b ? done_b : done_a}, 32'd0);
  endtask

  initial begin
    int n, n2;
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; bin_a = 8'd77; bin_b = 10'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_bcd_a", {20'd0, bcd_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
`ifdef BIN2BCD_OVF_EN
    chk("rst_ovf_b", {31'd0, ovf_b}, 32'd0);
`endif
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset_discarded", {31'd0, busy_a}, 32'd0);

    run_conv(1'b0, 16'd0,   13'h000);
    run_conv(1'b0, 16'd255, 13'h255);
    run_conv(1'b0, 16'd99,  13'h099);
    run_conv(1'b0, 16'd5,   13'h005);

    // start held through a whole conversion with bin_in wandering; restart in the DONE cycle.
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd128; exp_a.push_back(12'h128);
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a) break;
      bin_a = 8'(i * 37 + 1);
      @(posedge clk); #1;
      n++;
    end
    chk("held_start_latency", n, 8);
    bin_a = 8'd77; exp_a.push_back(12'h077);
    @(posedge clk); #1;
    start_a = 1'b0; bin_a = 8'hAA;
    n2 = 1;
    for (int i = 0; i < 40; i++) begin
      if (done_a) break;
      @(posedge clk); #1;
      n2++;
    end
    chk("back_to_back_spacing", n2, 9);
    $display("conv dut=a bin=128 then 77 back-to-back spacing=%0d", n2);
    @(posedge clk); #1;

    // Reset in the middle of a conversion of 200: aborted, no done pulse.
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; start_a = 1'b1; bin_a = 8'd99;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    chk("abort_bcd", {20'd0, bcd_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_bcd_after", {20'd0, bcd_a}, 32'd0);
    $display("conv dut=a bin=200 aborted by reset");
    run_conv(1'b0, 16'd42, 13'h042);

    // Wider operand: truncation above 999, overflow flag when enabled.
    run_conv(1'b1, 16'd1023, 13'h1023);
    run_conv(1'b1, 16'd999,  13'h0999);
    run_conv(1'b1, 16'd512,  13'h0512);

    repeat (3) @(posedge clk);
    chk("queue_a_empty", exp_a.size(), 0);
    chk("queue_b_empty", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
